simd_issue_unit: RTL

In-order fetch/issue front end for the SIMD GPU core. It owns the program counter and drives a synchronous instruction memory. It decodes the 16-bit instruction word and hands one ADD/MUL operation at a time to the execute stage (register file plus SIMD ALU) over a valid/ready handshake. A per-register scoreboard holds back any instruction that depends on a write still in flight.

---
 rtl/simd_issue_unit_if.sv | 52 +++++
 rtl/simd_issue_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/simd_issue_unit_if.sv
// -----------------------------------------------------------------------------
// simd_issue_unit_if
//
// Bundles the buses of the SIMD issue front end:
//   imem_addr   : instruction address (driven by the issue unit)
//   imem_rdata  : instruction word, one cycle after imem_addr
//   issue_*     : valid/ready handshake and decoded payload towards execute
//   wb_valid/rd : write-back notification from execute (scoreboard release)
//
// modport master : the issue unit
// modport slave  : instruction memory plus execute stage
// -----------------------------------------------------------------------------
interface simd_issue_unit_if #(
  parameter int IMEM_AW = 4
);
  logic [IMEM_AW-1:0] imem_addr;
  logic [15:0]        imem_rdata;
  logic               issue_valid;
  logic               issue_ready;
  logic [1:0]         issue_op;
  logic [2:0]         issue_rd;
  logic [2:0]         issue_rs1;
  logic [2:0]         issue_rs2;
  logic               wb_valid;
  logic [2:0]         wb_rd;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output issue_valid,
    input  issue_ready,
    output issue_op,
    output issue_rd,
    output issue_rs1,
    output issue_rs2,
    input  wb_valid,
    input  wb_rd
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  issue_valid,
    output issue_ready,
    input  issue_op,
    input  issue_rd,
    input  issue_rs1,
    input  issue_rs2,
    output wb_valid,
    output wb_rd
  );
endinterface

// File: rtl/simd_issue_unit.sv
// -----------------------------------------------------------------------------
// simd_issue_unit
//
// In-order fetch/issue front end of the SIMD GPU core. Owns the PC, reads a
// synchronous instruction memory, decodes 16-bit words and hands ADD/MUL
// operations to the execute stage one at a time over valid/ready.
//
// Instruction word: [15:14] op (00 ADD, 01 MUL, 10 NOP, 11 HALT),
//                   [13:11] rd, [10:8] rs1, [7:5] rs2, [4:0] ignored.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   start         : pulse, starts execution at PC 0 (only in IDLE/HALTED)
//   bus           : simd_issue_unit_if.master (imem, issue handshake, wb)
//   busy          : high in FETCH or ISSUE
//   halted        : high in HALTED
//   issued_count  : operations accepted since last reset/start (wraps)
//
// Build option SIMD_ISSUE_SCOREBOARD_EN:
//   defined   -> per-register scoreboard; ADD/MUL stall on RAW/WAW hazards
//                until the matching write-back arrives.
//   undefined -> no scoreboard, wb_valid/wb_rd ignored, no hazard stalls.
// -----------------------------------------------------------------------------
module simd_issue_unit #(
  parameter int IMEM_AW = 4,
  parameter int REGS    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  simd_issue_unit_if.master        bus,
  output logic                     busy,
  output logic                     halted,
  output logic [15:0]              issued_count
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  state_t             state_reg, state_next;
  logic [IMEM_AW-1:0] pc_reg, pc_next;
  logic [15:0]        count_reg, count_next;

  logic [1:0] dec_op;
  logic [2:0] dec_rd, dec_rs1, dec_rs2;
  logic       is_alu;
  logic       hazard;
  logic       valid_int;
  logic       issue_fire;

  // Decode straight from the memory output: imem_addr holds the PC while in
  // ISSUE, so the word is stable for as long as we stall.
  assign dec_op  = bus.imem_rdata[15:14];
  assign dec_rd  = bus.imem_rdata[13:11];
  assign dec_rs1 = bus.imem_rdata[10:8];
  assign dec_rs2 = bus.imem_rdata[7:5];

  logic unused_rdata;
  assign unused_rdata = ^bus.imem_rdata[4:0];

  assign is_alu     = (dec_op == OP_ADD) || (dec_op == OP_MUL);
  // issue_ready deliberately does not feed valid.
  assign valid_int  = (state_reg == ISSUE) && is_alu && !hazard;
  assign issue_fire = valid_int && bus.issue_ready;

`ifdef SIMD_ISSUE_SCOREBOARD_EN
  logic [REGS-1:0] sb_reg, sb_next, sb_eff, wb_clr, issue_set;

  for (genvar gi = 0; gi < REGS; gi++) begin : g_sb
    assign wb_clr[gi]    = bus.wb_valid && (bus.wb_rd == 3'(gi));
    assign issue_set[gi] = issue_fire && (dec_rd == 3'(gi));
  end

  // A write-back releases a stall in the same cycle it arrives.
  assign sb_eff  = sb_reg & ~wb_clr;
  // Set after clear: a same-cycle issue to the written-back rd stays pending.
  assign sb_next = sb_eff | issue_set;
  assign hazard  = sb_eff[dec_rs1] | sb_eff[dec_rs2] | sb_eff[dec_rd];

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_reg <= '0;
    end else begin
      sb_reg <= sb_next;
    end
  end
`else
  // Software guarantees spacing between dependent operations.
  logic            unused_wb;
  logic [REGS-1:0] unused_sb_stub;
  assign hazard         = 1'b0;
  assign unused_sb_stub = '0;
  assign unused_wb      = ^{bus.wb_valid, bus.wb_rd};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE, HALTED: begin
        if (start) begin
          pc_next    = '0;
          count_next = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = ISSUE;
      end
      ISSUE: begin
        if (dec_op == OP_HALT) begin
          state_next = HALTED;
        end else if (dec_op == OP_NOP) begin
          pc_next    = pc_reg + 1'b1;
          state_next = FETCH;
        end else if (issue_fire) begin
          pc_next    = pc_reg + 1'b1;
          count_next = count_reg + 16'd1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.issue_valid = valid_int;
  assign bus.issue_op    = valid_int ? dec_op  : 2'b00;
  assign bus.issue_rd    = valid_int ? dec_rd  : 3'b000;
  assign bus.issue_rs1   = valid_int ? dec_rs1 : 3'b000;
  assign bus.issue_rs2   = valid_int ? dec_rs2 : 3'b000;

  assign busy         = (state_reg == FETCH) || (state_reg == ISSUE);
  assign halted       = (state_reg == HALTED);
  assign issued_count = count_reg;

endmodule
